roi_scan_ctrl: RTL and testbench
================================

// Module: roi_scan_ctrl
// PURPOSE
//  Sequencer for the camera pixel-address counters. It scans a rectangular region of interest (ROI)
//  column-by-column, row-by-row, and emits (hcount, vcount) coordinates on a valid/ready stream.
//  Sits between the frame buffer readout and the downstream key-detection logic.
//  Replaces free-running event counters with a start/busy/done-controlled scan
//  that supports backpressure, inter-line gaps and abort.
// PARAMETERS
//  H_W         11  width of column coordinate / ROI width fields
//  V_W         10  width of row coordinate / ROI height fields
//  GAP_CYCLES  2   idle cycles inserted between rows (0 = no gap)
// PORTS
//  clk_in            in   1    system clock
//  rst_in            in   1    reset, asynchronous, active-high
//  start_in          in   1    request a scan; accepted only in IDLE
//  abort_in          in   1    cancel the scan in progress
//  x0_in             in   H_W  ROI left column, sampled on start acceptance
//  y0_in             in   V_W  ROI top row, sampled on start acceptance
//  width_in          in   H_W  ROI width in pixels, sampled on start acceptance
//  height_in         in   V_W  ROI height in rows, sampled on start acceptance
//  ready_in          in   1    downstream accepts the current coordinate
//  hcount_out        out  H_W  current column = x0 + col (mod 2^H_W)
//  vcount_out        out  V_W  current row = y0 + row (mod 2^V_W)
//  valid_out         out  1    coordinate on hcount/vcount is valid
//  last_in_line_out  out  1    current beat is the final column of its row
//  frame_done_out    out  1    one-cycle pulse after the final beat transfers
//  busy_out          out  1    high in any state other than IDLE
//  err_out           out  1    one-cycle pulse: start request had a zero-size ROI
// BEHAVIOUR
//  - States: IDLE, RUN, GAP, DONE. All outputs are registered.
//  - Reset (async, immediate, no clock edge needed): state=IDLE; col/row/gap counters=0.
//    All outputs=0.
//  - Transfer = valid_out && ready_in at a clk_in edge.
//  - IDLE:
//    - start_in=1, width or height = 0: pulse err_out for one cycle; stay IDLE.
//    - start_in=1, otherwise: latch config; col=row=0; next cycle enters RUN.
//      In that cycle valid_out=1, hcount=x0, vcount=y0.
//  - RUN: valid_out=1. If ready_in=0, every output holds stable.
//    On a transfer:
//    - col < width-1: col+1.
//    - col == width-1, row < height-1: col=0, row+1. Go to GAP, or straight to RUN if GAP_CYCLES=0.
//    - col == width-1, row == height-1: go to DONE.
//    - last_in_line_out = (col == width-1) && valid_out.
//  - GAP: valid_out=0 for exactly GAP_CYCLES cycles, then RUN with the new row at col 0.
//  - DONE: lasts one cycle. frame_done_out=1, valid_out=0, busy_out=1. Then IDLE.
//  - busy_out = (state != IDLE), registered with the state.
//  - start_in outside IDLE is ignored. Config inputs are sampled only on start acceptance.
//  - abort_in in RUN/GAP/DONE: next state IDLE, valid_out=0, busy_out=0.
//    frame_done_out is not asserted and is cleared if it was pending.
//    Abort beats a simultaneous transfer; that beat is still considered consumed downstream.
//  - abort_in and start_in together in IDLE: start is ignored, no err_out.
//  - Coordinate adds are H_W/V_W wide and wrap modulo 2^W. Internal col/row counters never wrap:
//    width/height cap them.
//  - Max ROI is 2^H_W-1 by 2^V_W-1. Total beats per frame = width*height.
// TESTING
//  1. x0=10,y0=5,w=3,h=2,GAP=2, ready=1 -> beats (10,5),(11,5),(12,5), 2 invalid cycles,
//     then (10,6),(11,6),(12,6).
//     last_in_line on (12,5),(12,6); frame_done 1 cycle after (12,6); busy drops next cycle.
//  2. Same ROI, ready_in toggles 1010… -> each coordinate held until it transfers;
//     same 6-beat sequence, no skips or repeats.
//  3. start with w=0, h=4 -> err_out=1 for one cycle; busy_out, valid_out stay 0.
//     A following valid start works normally.
//  4. Abort on beat (11,5) while ready=1 -> next cycle valid=0, busy=0, no frame_done.
//     A restart with new config begins at the new x0,y0.
//  5. H_W=11, x0=2046, w=4, h=1 -> hcount 2046,2047,0,1; last_in_line on hcount=1.
//  6. Async rst_in pulsed mid-RUN between clock edges -> all outputs 0 before the next edge;
//     state IDLE after release.

Source files
------------

// File: rtl/roi_scan_ctrl.sv
// rtl/roi_scan_ctrl.sv - ROI raster scan sequencer emitting (hcount, vcount) beats on a valid/ready stream
// Scans col-by-col, row-by-row with optional inter-row gap, abort and zero-size error reporting.
module roi_scan_ctrl #(
    parameter int H_W        = 11,
    parameter int V_W        = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start_in,
    input  logic           abort_in,
    input  logic [H_W-1:0] x0_in,
    input  logic [V_W-1:0] y0_in,
    input  logic [H_W-1:0] width_in,
    input  logic [V_W-1:0] height_in,
    input  logic           ready_in,
    output logic [H_W-1:0] hcount_out,
    output logic [V_W-1:0] vcount_out,
    output logic           valid_out,
    output logic           last_in_line_out,
    output logic           frame_done_out,
    output logic           busy_out,
    output logic           err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [H_W-1:0]   H_ONE    = H_W'(1);
    localparam logic [V_W-1:0]   V_ONE    = V_W'(1);

    state_t           state_q;
    logic [H_W-1:0]   col_q;
    logic [V_W-1:0]   row_q;
    logic [GAP_W-1:0] gap_q;
    logic [H_W-1:0]   x0_q;
    logic [V_W-1:0]   y0_q;
    logic [H_W-1:0]   w_q;
    logic [V_W-1:0]   h_q;

    logic [H_W-1:0]   hcount_q;
    logic [V_W-1:0]   vcount_q;
    logic             valid_q;
    logic             last_q;
    logic             done_q;
    logic             busy_q;
    logic             err_q;

    logic [H_W-1:0]   col_d;
    logic [V_W-1:0]   row_d;
    logic             line_end;
    logic             frame_end;

    // Counters stay below width/height, so the +1 never wraps; only the coordinate sums wrap.
    assign col_d     = col_q + H_ONE;
    assign row_d     = row_q + V_ONE;
    assign line_end  = (col_q == w_q - H_ONE);
    assign frame_end = line_end && (row_q == h_q - V_ONE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            gap_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (abort_in && (state_q != S_IDLE)) begin
                // A beat transferring on this edge counts as consumed; nothing more is emitted.
                state_q <= S_IDLE;
                col_q   <= '0;
                row_q   <= '0;
                gap_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_in && !abort_in) begin
                            if ((width_in == '0) || (height_in == '0)) begin
                                err_q <= 1'b1;
                            end else begin
                                x0_q     <= x0_in;
                                y0_q     <= y0_in;
                                w_q      <= width_in;
                                h_q      <= height_in;
                                col_q    <= '0;
                                row_q    <= '0;
                                state_q  <= S_RUN;
                                hcount_q <= x0_in;
                                vcount_q <= y0_in;
                                valid_q  <= 1'b1;
                                last_q   <= (width_in == H_ONE);
                                busy_q   <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (ready_in) begin
                            if (!line_end) begin
                                col_q    <= col_d;
                                hcount_q <= x0_q + col_d;
                                last_q   <= (col_d == w_q - H_ONE);
                            end else if (!frame_end) begin
                                col_q <= '0;
                                row_q <= row_d;
                                if (GAP_CYCLES == 0) begin
                                    hcount_q <= x0_q;
                                    vcount_q <= y0_q + row_d;
                                    last_q   <= (w_q == H_ONE);
                                end else begin
                                    state_q <= S_GAP;
                                    gap_q   <= '0;
                                    valid_q <= 1'b0;
                                    last_q  <= 1'b0;
                                end
                            end else begin
                                state_q <= S_DONE;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            state_q  <= S_RUN;
                            hcount_q <= x0_q;
                            vcount_q <= y0_q + row_q;
                            valid_q  <= 1'b1;
                            last_q   <= (w_q == H_ONE);
                        end else begin
                            gap_q <= gap_q + GAP_ONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        col_q   <= '0;
                        row_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hcount_out       = hcount_q;
    assign vcount_out       = vcount_q;
    assign valid_out        = valid_q;
    assign last_in_line_out = last_q;
    assign frame_done_out   = done_q;
    assign busy_out         = busy_q;
    assign err_out          = err_q;

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// tb/tb_roi_scan_ctrl.sv - scoreboard testbench for roi_scan_ctrl
module tb_roi_scan_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [10:0] x0_in = '0;
    logic [9:0]  y0_in = '0;
    logic [10:0] width_in = '0;
    logic [9:0]  height_in = '0;
    logic        ready_in = 1'b1;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        valid_out;
    logic        last_in_line_out;
    logic        frame_done_out;
    logic        busy_out;
    logic        err_out;

    roi_scan_ctrl #(.H_W(11), .V_W(10), .GAP_CYCLES(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
        .x0_in(x0_in), .y0_in(y0_in), .width_in(width_in), .height_in(height_in),
        .ready_in(ready_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .valid_out(valid_out), .last_in_line_out(last_in_line_out),
        .frame_done_out(frame_done_out), .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit tog = 1'b0;
    logic [21:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Beat key: {hcount, vcount, last}
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (frame_done_out) done_cnt++;
            if (err_out) err_cnt++;
            if (valid_out && ready_in) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", {10'd0, hcount_out, vcount_out, last_in_line_out}, 32'hFFFF_FFFF);
                end else begin
                    logic [21:0] e;
                    e = sb_q.pop_front();
                    check($sformatf("beat h=%0d v=%0d last=%0d", e[21:11], e[10:1], e[0]),
                          {10'd0, hcount_out, vcount_out, last_in_line_out}, {10'd0, e});
                end
            end
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (tog) ready_in = ~ready_in;
    end

    task automatic push_roi(input logic [10:0] x0, input logic [9:0] y0, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                logic [10:0] hc;
                logic [9:0]  vc;
                hc = x0 + 11'(c);
                vc = y0 + 10'(r);
                sb_q.push_back({hc, vc, (c == w - 1)});
            end
        end
    endtask

    task automatic pulse_start(input logic [10:0] x0, input logic [9:0] y0,
                               input logic [10:0] w, input logic [9:0] h);
        x0_in = x0; y0_in = y0; width_in = w; height_in = h;
        start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk_in);
            if (done_cnt != base) seen = 1'b1;
        end
        check({name, "_done_pulses"}, done_cnt, base + 1);
        @(posedge clk_in);
        #1;
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    logic [9:0] exp_valid = 10'b1110011100;
    logic [9:0] exp_done  = 10'b0000000010;
    logic [9:0] exp_busy  = 10'b1111111110;
    logic [9:0] exp_last  = 10'b0010000100;
    logic [9:0] got_valid, got_done, got_busy, got_last;

    initial begin
        #2;
        check("reset_outputs", {hcount_out, vcount_out, valid_out, last_in_line_out,
                                frame_done_out, busy_out, err_out}, 0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // 1: basic scan with gap
        ready_in = 1'b1;
        push_roi(11'd10, 10'd5, 3, 2);
        pulse_start(11'd10, 10'd5, 11'd3, 10'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            got_valid[9-i] = valid_out;
            got_done[9-i]  = frame_done_out;
            got_busy[9-i]  = busy_out;
            got_last[9-i]  = last_in_line_out;
        end
        check("t1_valid_pattern", got_valid, exp_valid);
        check("t1_done_pattern", got_done, exp_done);
        check("t1_busy_pattern", got_busy, exp_busy);
        check("t1_last_pattern", got_last, exp_last);
        check("t1_sb_empty", sb_q.size(), 0);
        @(posedge clk_in);
        #1;

        // 2: toggling backpressure, with an ignored start mid-scan
        tog = 1'b1;
        push_roi(11'd10, 10'd5, 3, 2);
        pulse_start(11'd10, 10'd5, 11'd3, 10'd2);
        repeat (4) @(posedge clk_in);
        #2;
        pulse_start(11'd500, 10'd9, 11'd1, 10'd1);
        wait_done("t2");
        tog = 1'b0;
        @(posedge clk_in);
        #2 ready_in = 1'b1;

        // 3: zero-size ROI error, then a good scan
        pulse_start(11'd0, 10'd0, 11'd0, 10'd4);
        @(negedge clk_in);
        check("t3_err_pulse", {err_out, busy_out, valid_out}, 3'b100);
        @(negedge clk_in);
        check("t3_err_cleared", {err_out, busy_out, valid_out}, 3'b000);
        @(posedge clk_in);
        #1;
        push_roi(11'd300, 10'd40, 2, 2);
        pulse_start(11'd300, 10'd40, 11'd2, 10'd2);
        wait_done("t3");

        // 4: abort on second beat
        begin
            int dbase;
            dbase = done_cnt;
            sb_q.push_back({11'd10, 10'd5, 1'b0});
            sb_q.push_back({11'd11, 10'd5, 1'b0});
            pulse_start(11'd10, 10'd5, 11'd3, 10'd2);
            @(posedge clk_in);
            #1 abort_in = 1'b1;
            @(posedge clk_in);
            #1 abort_in = 1'b0;
            @(negedge clk_in);
            check("t4_after_abort", {valid_out, busy_out, frame_done_out}, 3'b000);
            check("t4_sb_empty", sb_q.size(), 0);
            repeat (4) @(posedge clk_in);
            #1;
            check("t4_no_frame_done", done_cnt, dbase);
        end
        push_roi(11'd100, 10'd200, 1, 1);
        pulse_start(11'd100, 10'd200, 11'd1, 10'd1);
        wait_done("t4_restart");

        // abort and start together in IDLE
        begin
            int ebase;
            ebase = err_cnt;
            abort_in = 1'b1;
            pulse_start(11'd7, 10'd7, 11'd0, 10'd0);
            abort_in = 1'b0;
            @(negedge clk_in);
            check("idle_abort_start", {err_out, busy_out, valid_out}, 3'b000);
            check("idle_abort_no_err", err_cnt, ebase);
            @(posedge clk_in);
            #1;
        end

        // 5: horizontal coordinate wrap
        push_roi(11'd2046, 10'd7, 4, 1);
        pulse_start(11'd2046, 10'd7, 11'd4, 10'd1);
        wait_done("t5");

        // 6: async reset mid-run
        push_roi(11'd50, 10'd60, 5, 3);
        pulse_start(11'd50, 10'd60, 11'd5, 10'd3);
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        check("t6_async_reset", {hcount_out, vcount_out, valid_out, last_in_line_out,
                                 frame_done_out, busy_out, err_out}, 0);
        sb_q.delete();
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("t6_idle_after_release", {valid_out, busy_out, frame_done_out}, 3'b000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
